// File: rtl/spi_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_pkg
//  Purpose  : Shared word/channel geometry and receiver FSM encoding, so the
//             SPI master and the frame receiver agree on the frame layout.
//  Revision : 1.0  initial release
// ============================================================================
package spi_frame_pkg;

    // Frame geometry shared with spi_master
    localparam int DEF_DATA_W = 16;
    localparam int DEF_NUM_CH = 3;

    // Receiver FSM encoding
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

endpackage : spi_frame_pkg
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pin_sync
//  Purpose  : Multi-stage synchroniser for the asynchronous SPI pins plus edge
//             detection on Cs_n and Sclk_in. MOSI passes through the same
//             depth so its synced copy lines up with the synced Sclk rise.
//             SYNC_STAGES must be at least 2.
//  Revision : 1.0  initial release
// ============================================================================
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic cs_n_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic cs_fall_o,
    output logic cs_rise_o,
    output logic sclk_rise_o,
    output logic mosi_o
);

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   cs_prev_q;
    logic                   sclk_prev_q;

    logic w_cs_s;
    logic w_sclk_s;

    // Synchroniser chains and one-cycle history; preset to the idle bus state
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            cs_prev_q   <= w_cs_s;
            sclk_prev_q <= w_sclk_s;
        end
    end

    assign w_cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign w_sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_fall_o   = cs_prev_q & ~w_cs_s;
    assign cs_rise_o   = ~cs_prev_q & w_cs_s;
    assign sclk_rise_o = ~sclk_prev_q & w_sclk_s;
    assign mosi_o      = mosi_sync_q[SYNC_STAGES-1];

endmodule : spi_pin_sync
`default_nettype wire

// File: rtl/spi_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_receiver
//  Purpose  : SPI mode-0 slave deserialiser on the system clock. Rebuilds
//             DATA_W-bit words (MSB first), tags them with a rotating channel
//             index and classifies each Cs_n window as a good or bad frame.
//  Revision : 1.0  initial release
// ============================================================================
module spi_frame_receiver
    import spi_frame_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Cs_n,
    input  logic              Sclk_in,
    input  logic              MOSI,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        ch_id,
    output logic              data_valid,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam int                BCNT_W     = $clog2(DATA_W + 1);
    localparam logic [BCNT_W-1:0] C_BIT_LAST = BCNT_W'(DATA_W - 1);
    localparam logic [1:0]        C_CH_LAST  = 2'(NUM_CH - 1);

    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sclk_rise;
    logic w_mosi;

    // The shift register holds only the bits before the LSB; the LSB is
    // appended directly when the word is assembled.
    rx_state_e                state_q,      state_d;
    logic [DATA_W-2:0]        shift_q,      shift_d;
    logic [BCNT_W-1:0]        bit_cnt_q,    bit_cnt_d;
    logic [1:0]               ch_cnt_q,     ch_cnt_d;
    logic                     word_seen_q,  word_seen_d;
    logic [DATA_W-1:0]        data_out_q,   data_out_d;
    logic [1:0]               ch_id_q,      ch_id_d;
    logic                     dvalid_q,     dvalid_d;
    logic                     fdone_q,      fdone_d;
    logic                     ferr_q,       ferr_d;
    logic [15:0]              frame_cnt_q,  frame_cnt_d;

    // Counter values after this cycle's bit capture; the frame decision uses them
    logic [BCNT_W-1:0]        w_bit_post;
    logic [1:0]               w_ch_post;
    logic                     w_seen_post;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .cs_n_i      (Cs_n),
        .sclk_i      (Sclk_in),
        .mosi_i      (MOSI),
        .cs_fall_o   (w_cs_fall),
        .cs_rise_o   (w_cs_rise),
        .sclk_rise_o (w_sclk_rise),
        .mosi_o      (w_mosi)
    );

    // Next-state logic: bit capture first, then the Cs_n-rise frame decision
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ch_cnt_d    = ch_cnt_q;
        word_seen_d = word_seen_q;
        data_out_d  = data_out_q;
        ch_id_d     = ch_id_q;
        dvalid_d    = 1'b0;
        fdone_d     = 1'b0;
        ferr_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        w_bit_post  = bit_cnt_q;
        w_ch_post   = ch_cnt_q;
        w_seen_post = word_seen_q;

        case (state_q)
            IDLE: begin
                if (w_cs_fall) begin
                    state_d     = SHIFT;
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                    ch_cnt_d    = '0;
                    word_seen_d = 1'b0;
                end
            end

            SHIFT: begin
                if (w_sclk_rise) begin
                    if (bit_cnt_q == C_BIT_LAST) begin
                        data_out_d  = {shift_q, w_mosi};
                        ch_id_d     = ch_cnt_q;
                        dvalid_d    = 1'b1;
                        w_bit_post  = '0;
                        w_ch_post   = (ch_cnt_q == C_CH_LAST) ? 2'd0 : ch_cnt_q + 2'd1;
                        w_seen_post = 1'b1;
                    end else begin
                        shift_d    = {shift_q[DATA_W-3:0], w_mosi};
                        w_bit_post = bit_cnt_q + BCNT_W'(1);
                    end
                end
                bit_cnt_d   = w_bit_post;
                ch_cnt_d    = w_ch_post;
                word_seen_d = w_seen_post;

                if (w_cs_rise) begin
                    state_d = IDLE;
                    if ((w_bit_post == '0) && (w_ch_post == 2'd0) && w_seen_post) begin
                        fdone_d     = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else if ((w_bit_post != '0) || w_seen_post) begin
                        // Partial word simply stays in shift_q and is never published
                        ferr_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ch_cnt_q    <= '0;
            word_seen_q <= 1'b0;
            data_out_q  <= '0;
            ch_id_q     <= '0;
            dvalid_q    <= 1'b0;
            fdone_q     <= 1'b0;
            ferr_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ch_cnt_q    <= ch_cnt_d;
            word_seen_q <= word_seen_d;
            data_out_q  <= data_out_d;
            ch_id_q     <= ch_id_d;
            dvalid_q    <= dvalid_d;
            fdone_q     <= fdone_d;
            ferr_q      <= ferr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign data_out   = data_out_q;
    assign ch_id      = ch_id_q;
    assign data_valid = dvalid_q;
    assign frame_done = fdone_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q == SHIFT);
    assign frame_cnt  = frame_cnt_q;

endmodule : spi_frame_receiver
`default_nettype wire

// File: doc/spi_frame_receiver.md
Name: spi_frame_receiver

Overview:
- SPI slave deserialiser: the receiving end of the 3-channel ADC sample stream sent by spi_master (Cs_n, Clk_out, MOSI).
- Runs on the fast system clock (Clk_200 domain) and oversamples the asynchronous SPI pins.
- Reassembles 16-bit words, tags each with its channel index (0,1,2 repeating) and flags malformed frames.
- Used on the collector board and as the loopback checker for the sampling FPGA.

Parameters:
- DATA_W, 16, bits per word; transmitted MSB first.
- NUM_CH, 3, words per channel set; ch_id wraps after NUM_CH-1.
- SYNC_STAGES, 2, synchroniser flops on Cs_n, Sclk_in and MOSI; all three use the same depth.

Ports:
- Clk  in  1  system clock; must be >= 4x the Sclk_in frequency.
- Rst_n  in  1  asynchronous, active-low reset.
- Cs_n  in  1  SPI chip select, active low, asynchronous to Clk.
- Sclk_in  in  1  SPI clock (spi_master Clk_out); idles low (mode 0).
- MOSI  in  1  SPI serial data.
- data_out  out  DATA_W  last completed word; held until the next word completes.
- ch_id  out  2  channel index of data_out.
- data_valid  out  1  one-cycle strobe: data_out/ch_id are new.
- frame_done  out  1  one-cycle strobe: Cs_n rose after a whole number of channel sets.
- frame_err  out  1  one-cycle strobe: Cs_n rose mid-word or mid-set.
- busy  out  1  high while the FSM is in SHIFT.
- frame_cnt  out  16  count of good frames; wraps 0xFFFF -> 0.

Behaviour:
- Reset (async assert, sync release):
  - data_out=0, ch_id=0, data_valid=0, frame_done=0, frame_err=0, busy=0, frame_cnt=0.
  - Synchronisers preset to idle: Cs_n=1, Sclk=0, MOSI=0.
  - Bit counter, channel counter and shift register cleared; FSM goes to IDLE.
- Edge detect:
  - sclk_rise = synced Sclk 0->1.
  - cs_fall / cs_rise on synced Cs_n.
  - MOSI is sampled from its synced copy in the same cycle as sclk_rise (equal pipeline depth, so the two stay aligned).
- FSM, IDLE:
  - Sclk edges are ignored.
  - cs_fall -> SHIFT; clears bit_cnt and ch_cnt; busy=1 from the next cycle.
- FSM, SHIFT:
  - On each sclk_rise: shift_reg <= {shift_reg[DATA_W-2:0], mosi_s}; bit_cnt++.
  - On the DATA_W-th bit, in the next cycle:
    - data_out <= assembled word; ch_id <= ch_cnt; data_valid=1.
    - bit_cnt <= 0; ch_cnt <= (ch_cnt==NUM_CH-1) ? 0 : ch_cnt+1.
  - Latency: data_valid is asserted exactly 1 Clk cycle after the synced sclk_rise that captures the LSB.
- FSM, on cs_rise in SHIFT -> IDLE:
  - bit_cnt==0 and ch_cnt==0 and at least one word received -> frame_done=1; frame_cnt++.
  - Otherwise -> frame_err=1; the partial word is discarded (no data_valid); frame_cnt unchanged.
  - cs_rise with zero bits received is neither done nor err: a silent return to IDLE.
- Simultaneous events:
  - LSB sclk_rise and cs_rise in the same cycle: the bit is captured and the word completes first. The data_valid strobe and the frame_done/err decision use the post-capture counters, so a complete final word yields data_valid and frame_done in the same cycle.
  - Sclk edges in the cycle of cs_fall are ignored.
- Strobes are never asserted for more than one cycle; data_valid is not stretched.
- Reset mid-frame: everything aborts immediately, with no strobes; the receiver needs a fresh cs_fall to resume.
- Counter widths: bit_cnt = clog2(DATA_W+1); ch_cnt = 2 bits, which requires NUM_CH <= 4.

Decomposition:
- Shared package spi_frame_pkg:
  - DATA_W and NUM_CH defaults, so spi_master and the receiver stay in lock-step.
  - FSM state encoding: IDLE=1'b0, SHIFT=1'b1.
- One natural sub-module, spi_pin_sync: SYNC_STAGES-deep synchroniser plus rise/fall detection for Cs_n and Sclk_in, with a matching delay on MOSI.
- The FSM, shift register and counters stay in the top.

Test Plan:
- Single set: Cs_n low; send 0x1234, 0xABCD, 0x8001; Cs_n high -> three data_valid strobes with ch_id 0,1,2 and these values; then frame_done=1, frame_cnt=1.
- Two sets in one Cs_n window: send 0x0001..0x0006 -> ch_id sequence 0,1,2,0,1,2; one frame_done; frame_cnt increments by 1.
- Short frame: send 0xFFFF, then 7 bits of 0x00; raise Cs_n -> one data_valid (0xFFFF, ch 0); frame_err=1; no second data_valid; frame_cnt unchanged.
- Word-complete but set-incomplete: send 2 words, then raise Cs_n -> 2 data_valid strobes, then frame_err=1.
- Reset mid-word: assert Rst_n low after 9 bits, release, then send a clean 3-word frame -> all outputs 0 during reset; the next frame decodes correctly with ch_id starting at 0.
- Max rate / edge coincidence:
  - Sclk_in at Clk/4 with the LSB rise and Cs_n rise in the same synced cycle -> data_valid and frame_done in the same cycle; values correct.
  - frame_cnt preset to 0xFFFF via 65535 frames (or force) wraps to 0.
